// File: rtl/gray_code_counter.sv
// gray_code_counter
//   Synchronous up/down binary counter that also produces the Gray code of its
//   count. It feeds the downstream Gray-to-binary converter. The binary state
//   is exposed so the converter output can be cross-checked in-system.
//
// Parameters
//   WIDTH     counter width in bits (>= 2), shared by gray_out and bin_out
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   en        advance the count by one step this cycle
//   up_dn     direction: 1 = up, 0 = down (applies on the next en step)
//   load      load load_bin this cycle (wins over en)
//   load_bin  binary value to load
//   gray_out  registered Gray code of the current count
//   bin_out   registered binary count
//   tc        terminal count in the current direction (combinational)
//   wrap      one-cycle pulse that coincides with a wrapped value
//   err       sticky Gray-adjacency error flag
//
// Build option
//   GRAY_CHECK_EN  when defined, adds an adjacency checker that drives err.
//                  When undefined, err is tied to 0.
module gray_code_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] MAX  = '1;

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             step;       // this edge performs an en step

    // Gray is derived from the *next* binary value, so both registers change
    // on the same edge and always describe the same count.
    always_comb begin
        bin_d  = bin_q;
        gray_d = gray_q;
        wrap_d = 1'b0;
        step   = 1'b0;
        if (load) begin
            bin_d  = load_bin;
            gray_d = load_bin ^ (load_bin >> 1);
        end else if (en) begin
            step   = 1'b1;
            bin_d  = up_dn ? (bin_q + ONE) : (bin_q - ONE);
            gray_d = bin_d ^ (bin_d >> 1);
            wrap_d = up_dn ? (bin_q == MAX) : (bin_q == ZERO);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;
    assign tc       = up_dn ? (bin_q == MAX) : (bin_q == ZERO);

`ifdef GRAY_CHECK_EN
    // The checker observes the gray_out port itself rather than gray_q, so it
    // judges exactly what the downstream converter receives.
    logic [WIDTH-1:0] gray_prev_q;
    logic             chk_q;      // previous edge was a plain en step
    logic             err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gray_prev_q <= '0;
            chk_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            gray_prev_q <= gray_out;
            chk_q       <= step;
            if (chk_q && ($countones(gray_prev_q ^ gray_out) != 1))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
